// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: receiver/transmitter state encoding,
//               the legal oversampling ratios and a helper that maps any other
//               ratio onto the default one.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Frame state encoding, shared by the RX and TX engines.
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_START  = 4'd1,
        ST_DATA   = 4'd2,
        ST_PARITY = 4'd3,
        ST_STOP   = 4'd4
    } uart_state_e;

    localparam logic [5:0] c_prescale_8  = 6'd8;
    localparam logic [5:0] c_prescale_16 = 6'd16;
    localparam logic [5:0] c_prescale_32 = 6'd32;

    // Anything other than 16 or 32 oversamples per bit runs at 8.
    function automatic logic [5:0] legal_prescale(input logic [5:0] prescale);
        case (prescale)
            c_prescale_16: legal_prescale = c_prescale_16;
            c_prescale_32: legal_prescale = c_prescale_32;
            default:       legal_prescale = c_prescale_8;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sampler
// Description : Bit-period edge counter and 2-of-3 majority sampler. The
//               counter runs 0..prescale-1 and wraps; the line is sampled at
//               the three counts around mid-bit and voted.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sampler
    import uart_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       i_clear,
    input  logic       i_enable,
    input  logic [5:0] i_prescale,
    input  logic       i_rx,
    output logic       sampled_bit,
    output logic       bit_done
);

    logic [5:0] r_edge_cnt;
    logic [2:0] r_samples;
    logic [5:0] w_half;
    logic       w_last;

    assign w_half = {1'b0, i_prescale[5:1]};
    assign w_last = (r_edge_cnt == (i_prescale - 6'd1));

    // Edge counter: restarts on a new frame, otherwise wraps once per bit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_edge_cnt <= '0;
        end else if (i_clear) begin
            r_edge_cnt <= '0;
        end else if (i_enable) begin
            r_edge_cnt <= w_last ? 6'd0 : (r_edge_cnt + 6'd1);
        end
    end

    // Capture the line at the three mid-bit counts for the vote.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_samples <= '0;
        end else if (i_enable && !i_clear) begin
            if (r_edge_cnt == (w_half - 6'd1)) r_samples[0] <= i_rx;
            if (r_edge_cnt == w_half)          r_samples[1] <= i_rx;
            if (r_edge_cnt == (w_half + 6'd1)) r_samples[2] <= i_rx;
        end
    end

    // The vote is settled well before the last count of the bit, where it is used.
    assign sampled_bit = (r_samples[0] & r_samples[1]) |
                         (r_samples[0] & r_samples[2]) |
                         (r_samples[1] & r_samples[2]);

    // bit_done is deliberately independent of i_clear: the top derives its
    // frame-restart decision from bit_done.
    assign bit_done = i_enable && w_last;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : Oversampling UART receiver. Start bit, DATA_WIDTH bits LSB
//               first, optional even/odd parity, one stop bit. Presents the
//               payload with a one-cycle valid pulse on error-free frames.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [5:0]            Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Par_Err,
    output logic                  Stp_Err
);

    localparam int c_cnt_w = $clog2(DATA_WIDTH + 1);

    uart_state_e           r_state;
    uart_state_e           w_next_state;
    logic [5:0]            r_prescale;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_p_data;
    logic [c_cnt_w-1:0]    r_bit_cnt;
    logic                  r_data_valid;
    logic                  r_par_err;
    logic                  r_stp_err;
    logic                  w_sampled_bit;
    logic                  w_bit_done;
    logic                  w_start;
    logic                  w_frame_ok;
    logic                  w_last_data;
    logic                  w_exp_parity;

    uart_rx_sampler u_sampler (
        .CLK         (CLK),
        .RST         (RST),
        .i_clear     (w_start),
        .i_enable    (r_state != ST_IDLE),
        .i_prescale  (r_prescale),
        .i_rx        (RX_IN),
        .sampled_bit (w_sampled_bit),
        .bit_done    (w_bit_done)
    );

    assign w_last_data  = (r_bit_cnt == c_cnt_w'(DATA_WIDTH - 1));
    assign w_exp_parity = r_par_typ ? ~(^r_shift) : (^r_shift);

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic. The last edge of a good stop bit also acts as the
    // first IDLE decision, so a start bit that follows immediately loses no cycle.
    always_comb begin
        w_next_state = r_state;
        w_frame_ok   = 1'b0;
        w_start      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!RX_IN) begin
                    w_start      = 1'b1;
                    w_next_state = ST_START;
                end
            end
            ST_START: begin
                if (w_bit_done) begin
                    w_next_state = w_sampled_bit ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_done && w_last_data) begin
                    w_next_state = r_par_en ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (w_bit_done) begin
                    w_next_state = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_bit_done) begin
                    w_frame_ok = w_sampled_bit && !r_par_err;
                    if (w_frame_ok && !RX_IN) begin
                        w_start      = 1'b1;
                        w_next_state = ST_START;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Frame configuration is frozen at the start of each frame.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_prescale <= c_prescale_8;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
        end else if (w_start) begin
            r_prescale <= legal_prescale(Prescale);
            r_par_en   <= PAR_EN;
            r_par_typ  <= PAR_TYP;
        end
    end

    // Payload shift register (LSB arrives first) and data-bit counter.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_start) begin
            r_bit_cnt <= '0;
        end else if ((r_state == ST_DATA) && w_bit_done) begin
            r_shift   <= {w_sampled_bit, r_shift[DATA_WIDTH-1:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end

    // Error flags: cleared when a frame starts, sticky until the next one.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_par_err <= 1'b0;
            r_stp_err <= 1'b0;
        end else if (w_start) begin
            r_par_err <= 1'b0;
            r_stp_err <= 1'b0;
        end else begin
            if ((r_state == ST_PARITY) && w_bit_done && (w_sampled_bit != w_exp_parity)) begin
                r_par_err <= 1'b1;
            end
            if ((r_state == ST_STOP) && w_bit_done && !w_sampled_bit) begin
                r_stp_err <= 1'b1;
            end
        end
    end

    // Hand the payload over only for frames with good parity and stop bit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_p_data     <= '0;
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= w_frame_ok;
            if (w_frame_ok) begin
                r_p_data <= r_shift;
            end
        end
    end

    assign P_DATA     = r_p_data;
    assign Data_Valid = r_data_valid;
    assign Par_Err    = r_par_err;
    assign Stp_Err    = r_stp_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx: directed frame table,
//               randomized frames against a frame-level reference model, and
//               hand-written back-to-back, glitch and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic [5:0] Prescale = 6'd8;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       Par_Err;
    logic       Stp_Err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    uart_rx #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .Prescale   (Prescale),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .Par_Err    (Par_Err),
        .Stp_Err    (Stp_Err)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } pulse_t;

    pulse_t pulses[$];

    // Every cycle with Data_Valid high is logged, so a stretched pulse shows up as extra entries.
    always @(negedge CLK) begin
        if (Data_Valid === 1'b1) pulses.push_back('{cyc: cyc, data: P_DATA});
    end

    typedef struct {
        logic [5:0] p_in;
        int         p_line;
        logic       pe;
        logic       pt;
        logic [7:0] d;
        logic       pbit;
        logic       sbit;
        logic       exp_v;
        logic [7:0] exp_d;
        logic       exp_pe;
        logic       exp_se;
        int         lat;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b, input int n);
        RX_IN = b;
        repeat (n) @(negedge CLK);
    endtask

    task automatic idle(input int n);
        drive_bit(1'b1, n);
    endtask

    // Called on a negedge; the start bit is seen on the next posedge, numbered t0.
    task automatic send_frame(input int p, input logic pe, input logic [7:0] d,
                              input logic pbit, input logic sbit, output int t0);
        t0 = cyc + 1;
        drive_bit(1'b0, p);
        for (int i = 0; i < 8; i++) drive_bit(d[i], p);
        if (pe) drive_bit(pbit, p);
        drive_bit(sbit, p);
    endtask

    task automatic finish_frame(input string tag, input int t0, input int lat, input logic exp_v,
                                input logic [7:0] exp_d, input logic exp_pe, input logic exp_se);
        idle(4);
        check({tag, " pulse count"}, 32'(pulses.size()), exp_v ? 32'd1 : 32'd0);
        if (exp_v && pulses.size() > 0) begin
            check({tag, " latency"}, 32'(pulses[0].cyc - t0), 32'(lat));
            check({tag, " pulse data"}, 32'(pulses[0].data), 32'(exp_d));
        end
        check({tag, " P_DATA"}, 32'(P_DATA), 32'(exp_d));
        check({tag, " Par_Err"}, 32'(Par_Err), 32'(exp_pe));
        check({tag, " Stp_Err"}, 32'(Stp_Err), 32'(exp_se));
        check({tag, " Data_Valid idle"}, 32'(Data_Valid), 32'd0);
        pulses.delete();
    endtask

    initial begin : main
        int         t0;
        int         ta;
        int         tb;
        int         tc;
        int         p;
        logic       pe;
        logic       pt;
        logic [7:0] d;
        logic       bad_par;
        logic       bad_stop;
        logic       pbit;
        logic       exp_v;
        logic [7:0] ref_pdata;

        //            p_in  line pe    pt    data   pbit  sbit  v     exp_d  pe_e  se_e  lat
        vecs[0] = '{6'd8,  8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 80};
        vecs[1] = '{6'd16, 16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 176};
        vecs[2] = '{6'd16, 16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 176};
        vecs[3] = '{6'd32, 32, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 320};
        vecs[4] = '{6'd8,  8,  1'b1, 1'b1, 8'h07, 1'b0, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0, 88};
        vecs[5] = '{6'd12, 8,  1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 80};
        vecs[6] = '{6'd32, 32, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 352};
        vecs[7] = '{6'd8,  8,  1'b1, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 88};

        // Reset state
        repeat (3) @(negedge CLK);
        check("reset P_DATA", 32'(P_DATA), 32'd0);
        check("reset Data_Valid", 32'(Data_Valid), 32'd0);
        check("reset Par_Err", 32'(Par_Err), 32'd0);
        check("reset Stp_Err", 32'(Stp_Err), 32'd0);
        RST = 1'b1;
        idle(4);

        // Short low pulse on the line is rejected as a false start
        pulses.delete();
        drive_bit(1'b0, 3);
        idle(24);
        check("false start pulses", 32'(pulses.size()), 32'd0);
        check("false start P_DATA", 32'(P_DATA), 32'd0);
        check("false start Par_Err", 32'(Par_Err), 32'd0);
        check("false start Stp_Err", 32'(Stp_Err), 32'd0);
        pulses.delete();

        // Directed frame table
        for (int i = 0; i < 8; i++) begin
            Prescale = vecs[i].p_in;
            PAR_EN   = vecs[i].pe;
            PAR_TYP  = vecs[i].pt;
            pulses.delete();
            send_frame(vecs[i].p_line, vecs[i].pe, vecs[i].d, vecs[i].pbit, vecs[i].sbit, t0);
            finish_frame($sformatf("vec%0d", i), t0, vecs[i].lat, vecs[i].exp_v,
                         vecs[i].exp_d, vecs[i].exp_pe, vecs[i].exp_se);
        end

        // Randomized frames against a frame-level reference model
        ref_pdata = 8'hFF;
        for (int n = 0; n < 12; n++) begin
            p        = 8 << $urandom_range(0, 2);
            pe       = 1'($urandom_range(0, 1));
            pt       = 1'($urandom_range(0, 1));
            d        = 8'($urandom_range(0, 255));
            bad_par  = ($urandom_range(0, 3) == 0);
            bad_stop = ($urandom_range(0, 4) == 0);
            // Parity bit that makes the count of ones even (pt=0) or odd (pt=1), then optionally corrupted.
            pbit     = 1'(($countones(d) + int'(pt)) % 2) ^ bad_par;
            exp_v    = !(pe && bad_par) && !bad_stop;
            if (exp_v) ref_pdata = d;
            Prescale = 6'(p);
            PAR_EN   = pe;
            PAR_TYP  = pt;
            pulses.delete();
            send_frame(p, pe, d, pbit, !bad_stop, t0);
            finish_frame($sformatf("rand%0d", n), t0, (10 + int'(pe)) * p, exp_v,
                         ref_pdata, pe && bad_par, bad_stop);
        end

        // Back-to-back frames with no idle gap
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        pulses.delete();
        send_frame(8, 1'b0, 8'hAA, 1'b0, 1'b1, ta);
        send_frame(8, 1'b0, 8'hCC, 1'b0, 1'b1, tb);
        send_frame(8, 1'b0, 8'h0F, 1'b0, 1'b1, tc);
        idle(4);
        check("b2b pulse count", 32'(pulses.size()), 32'd3);
        if (pulses.size() == 3) begin
            check("b2b first latency", 32'(pulses[0].cyc - ta), 32'd80);
            check("b2b spacing 1", 32'(pulses[1].cyc - pulses[0].cyc), 32'd80);
            check("b2b spacing 2", 32'(pulses[2].cyc - pulses[1].cyc), 32'd80);
            check("b2b data 0", 32'(pulses[0].data), 32'hAA);
            check("b2b data 1", 32'(pulses[1].data), 32'hCC);
            check("b2b data 2", 32'(pulses[2].data), 32'h0F);
        end
        check("b2b P_DATA", 32'(P_DATA), 32'h0F);
        pulses.delete();

        // One-cycle glitch on the centre sample of data bit 3 of 0x00
        Prescale = 6'd16;
        t0 = cyc + 1;
        drive_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                drive_bit(1'b0, 9);
                drive_bit(1'b1, 1);
                drive_bit(1'b0, 6);
            end else begin
                drive_bit(1'b0, 16);
            end
        end
        drive_bit(1'b1, 16);
        finish_frame("centre glitch", t0, 160, 1'b1, 8'h00, 1'b0, 1'b0);

        // Reset in the middle of data bit 5 of the next frame
        drive_bit(1'b0, 16);
        for (int i = 0; i < 5; i++) drive_bit(1'b1, 16);
        drive_bit(1'b1, 8);
        RST = 1'b0;
        #1;
        check("midframe reset P_DATA", 32'(P_DATA), 32'd0);
        check("midframe reset Data_Valid", 32'(Data_Valid), 32'd0);
        check("midframe reset Par_Err", 32'(Par_Err), 32'd0);
        check("midframe reset Stp_Err", 32'(Stp_Err), 32'd0);
        @(negedge CLK);
        idle(4);
        RST = 1'b1;
        idle(64);
        check("aborted frame pulses", 32'(pulses.size()), 32'd0);
        pulses.delete();

        // Receiver is back in IDLE and takes a fresh frame
        Prescale = 6'd8;
        send_frame(8, 1'b0, 8'h33, 1'b0, 1'b1, t0);
        finish_frame("post reset", t0, 80, 1'b1, 8'h33, 1'b0, 1'b0);

        // Asynchronous reset clears a non-zero payload immediately
        RST = 1'b0;
        #1;
        check("async reset P_DATA", 32'(P_DATA), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
